// File: rtl/mux_register_rr.sv
// mux_register_rr: N-channel, W-bit registered multiplexer with a valid/ready
// output stage. Each channel is picked either by an explicit select or by
// round-robin arbitration starting at a rotating pointer.
// Optional feature macro: MUXREG_PARITY_EN adds a registered even-parity output
// (parity_out) that is captured together with d_out.
module mux_register_rr #(
  parameter int  WIDTH    = 3,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       grant_out,
  input  logic                      ready_in,
  output logic [WIDTH-1:0]          d_out,
  output logic [SEL_W-1:0]          ch_out,
`ifdef MUXREG_PARITY_EN
  output logic                      parity_out,
`endif
  output logic                      valid_out
);

  logic [WIDTH-1:0] r_d_out;
  logic [SEL_W-1:0] r_ch_out;
  logic             r_valid_out;
  logic [SEL_W-1:0] r_ptr;

  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_sel_ok;
  logic [SEL_W-1:0] w_g;
  logic             w_cand;
  logic             w_slot_free;
  logic             w_load;
  logic [WIDTH-1:0] w_data;
  logic [SEL_W-1:0] w_ptr_inc;

  // Round-robin search: scan ptr, ptr+1, ... cyclically; walking backwards
  // lets the channel closest to ptr overwrite any later match.
  always_comb begin
    int idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (valid_in[SEL_W'(idx)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = SEL_W'(idx);
      end
    end
  end

  // Explicit select is only a candidate when sel names a real, valid channel.
  assign w_sel_ok = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS)) && valid_in[sel];

  assign w_g         = mode ? w_rr_idx : sel;
  assign w_cand      = mode ? w_rr_found : w_sel_ok;
  assign w_slot_free = !r_valid_out || ready_in;
  // Gating with reset keeps grant_out low while reset is held.
  assign w_load      = !reset && en && w_cand && w_slot_free;
  assign w_data      = d_in[int'(w_g)*WIDTH +: WIDTH];
  assign w_ptr_inc   = (int'(w_g) == CHANNELS - 1) ? '0 : w_g + 1'b1;

  // One-hot grant decode, only during a load cycle.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_grant
      assign grant_out[gi] = w_load && (int'(w_g) == gi);
    end
  endgenerate

`ifdef MUXREG_PARITY_EN
  logic r_parity;

  // Parity of the captured word, held alongside d_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_parity <= 1'b0;
    else if (w_load) r_parity <= ^w_data;
  end

  assign parity_out = r_parity;
`endif

  // Output register: load on grant, otherwise drop valid once consumed.
  // Data and channel hold after a drain; only valid falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_out     <= '0;
      r_ch_out    <= '0;
      r_valid_out <= 1'b0;
    end else if (w_load) begin
      r_d_out     <= w_data;
      r_ch_out    <= w_g;
      r_valid_out <= 1'b1;
    end else if (ready_in) begin
      r_valid_out <= 1'b0;
    end
  end

  // Pointer advances past the granted channel only on round-robin loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_ptr <= '0;
    else if (w_load && mode) r_ptr <= w_ptr_inc;
  end

  assign d_out     = r_d_out;
  assign ch_out    = r_ch_out;
  assign valid_out = r_valid_out;

endmodule

// File: tb/tb_mux_register_rr.sv
// tb_mux_register_rr: directed-vector bench for mux_register_rr (4 ch x 3 bit).
`timescale 1ns/1ps
module tb_mux_register_rr;

  localparam int WIDTH    = 3;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] d_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS-1:0]       grant_out;
  logic                      ready_in;
  logic [WIDTH-1:0]          d_out;
  logic [SEL_W-1:0]          ch_out;
  logic                      valid_out;
`ifdef MUXREG_PARITY_EN
  logic                      parity_out;
`endif

  int checks   = 0;
  int failures = 0;

  mux_register_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .d_in      (d_in),
    .valid_in  (valid_in),
    .grant_out (grant_out),
    .ready_in  (ready_in),
    .d_out     (d_out),
    .ch_out    (ch_out),
`ifdef MUXREG_PARITY_EN
    .parity_out(parity_out),
`endif
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned d, input int unsigned ch,
                           input int unsigned v);
    check_val({tag, "_d_out"}, d_out, d);
    check_val({tag, "_ch_out"}, ch_out, ch);
    check_val({tag, "_valid_out"}, valid_out, v);
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    mode     = 1'b1;
    sel      = '0;
    valid_in = 4'b1111;
    ready_in = 1'b1;
    d_in     = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    check_out("reset", 0, 0, 0);
    check_val("reset_grant", grant_out, 0);

    // Release reset, then explicit select of channel 2.
    reset    = 1'b0;
    mode     = 1'b0;
    sel      = 2'd2;
    valid_in = 4'b0100;
    d_in     = {3'd0, 3'b110, 3'd0, 3'd0};
    #1;
    check_val("sel2_grant", grant_out, 4'b0100);
    tick();
    check_out("sel2", 6, 2, 1);

    // Selected channel not valid: no load, item drains.
    valid_in = 4'b0000;
    #1;
    check_val("sel2_novalid_grant", grant_out, 0);
    tick();
    check_out("sel2_drain", 6, 2, 0);

    // Round robin, all valid, channel c carries c+1; ptr is still 0.
    mode     = 1'b1;
    valid_in = 4'b1111;
    d_in     = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 8; i++) begin
      #1;
      check_val($sformatf("rr%0d_grant", i), grant_out, 1 << (i % 4));
      tick();
      check_val($sformatf("rr%0d_ch", i), ch_out, i % 4);
      check_val($sformatf("rr%0d_d", i), d_out, (i % 4) + 1);
    end

    // Two more grants (ch0, ch1), then only channels 1 and 3 valid.
    tick();
    check_val("rr_pre_ch0", ch_out, 0);
    tick();
    check_val("rr_pre_ch1", ch_out, 1);
    valid_in = 4'b1010;
    #1;
    check_val("rr1010_a_grant", grant_out, 4'b1000);
    tick();
    check_out("rr1010_a", 4, 3, 1);
    check_val("rr1010_b_grant", grant_out, 4'b0010);
    tick();
    check_out("rr1010_b", 2, 1, 1);

    // Backpressure: ptr now 2, slot occupied by ch1 data.
    valid_in = 4'b1111;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("stall%0d_grant", i), grant_out, 0);
      tick();
      check_out($sformatf("stall%0d", i), 2, 1, 1);
    end
    ready_in = 1'b1;
    #1;
    check_val("unstall_grant", grant_out, 4'b0100);
    tick();
    check_out("unstall", 3, 2, 1);

    // Enable low: drain only.
    en = 1'b0;
    #1;
    check_val("en0_grant", grant_out, 0);
    tick();
    check_out("en0_drain", 3, 2, 0);
    check_val("en0_grant_after", grant_out, 0);

    // Load 3'b101 from ch1, then reset asynchronously while stalled.
    en       = 1'b1;
    mode     = 1'b0;
    sel      = 2'd1;
    valid_in = 4'b0010;
    d_in     = {3'd0, 3'd0, 3'b101, 3'd0};
    tick();
    check_out("preload", 5, 1, 1);
    ready_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 0);
    check_val("async_reset_grant", grant_out, 0);
    tick();
    reset    = 1'b0;
    mode     = 1'b1;
    valid_in = 4'b1111;
    ready_in = 1'b1;
    d_in     = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    check_val("post_reset_grant", grant_out, 4'b0001);
    tick();
    check_out("post_reset", 1, 0, 1);

`ifdef MUXREG_PARITY_EN
    mode     = 1'b0;
    sel      = 2'd0;
    valid_in = 4'b0001;
    d_in     = {3'd0, 3'd0, 3'd0, 3'b111};
    tick();
    check_val("parity_111_d", d_out, 7);
    check_val("parity_111", parity_out, 1);
    d_in = {3'd0, 3'd0, 3'd0, 3'b110};
    tick();
    check_val("parity_110_d", d_out, 6);
    check_val("parity_110", parity_out, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
